rs_generic: RTL and testbench
=============================

RS_GENERIC -- requirements
Module: rs_generic

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning number of station entries (≥2).
REQ-002 The module SHALL have parameter CDB_PORTS, default 2, meaning number of result broadcast ports.
REQ-003 The module SHALL have parameter TAG_W, default 4, meaning ROB tag width.
REQ-004 The module SHALL have parameter XLEN, default 32, meaning operand width.
REQ-005 The module SHALL have parameter OP_W, default 16, meaning opaque opcode/control payload width.
REQ-006 The module SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  mispredict flush.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  free entry exists.
- disp_op  in  OP_W  payload.
- disp_dest  in  TAG_W  destination tag.
- disp_src1_rdy, disp_src2_rdy  in  1  operand already valid.
- disp_src1_tag, disp_src2_tag  in  TAG_W  producer tag.
- disp_src1_val, disp_src2_val  in  XLEN  operand value.
- cdb_valid  in  CDB_PORTS  broadcast valid.
- cdb_tag  in  CDB_PORTS*TAG_W  broadcast tags.
- cdb_data  in  CDB_PORTS*XLEN  broadcast data.
- iss_valid  out  1  issue request.
- iss_ready  in  1  unit accepts.
- iss_op  out  OP_W  issued payload.
- iss_dest  out  TAG_W  issued destination tag.
- iss_src1, iss_src2  out  XLEN  issued operands.
- occupancy  out  $clog2(DEPTH+1)  valid entry count.
REQ-007 The module SHALL use the single clock clk; rst SHALL be synchronous and active-high.

Function
REQ-008 disp_ready SHALL be 1 iff at least one entry is invalid in the current registered state, independent of disp_valid, iss_ready and flush.
REQ-009 Dispatch SHALL occur on disp_valid && disp_ready and SHALL write the lowest-index invalid entry at the clock edge.
REQ-010 At dispatch, a not-ready source whose tag matches a valid cdb_tag in the same cycle SHALL be captured as ready with that cdb_data.
REQ-011 Each cycle, every valid entry's waiting source matching a valid cdb_tag SHALL capture cdb_data and become ready at the edge.
REQ-012 On multiple ports matching one tag, the lowest port index SHALL win.
REQ-013 An entry SHALL be issue-eligible when valid with both sources ready in registered state, so a woken entry is eligible the cycle after wakeup.
REQ-014 iss_valid SHALL be 1 iff an eligible entry exists; iss_* fields SHALL come combinationally from the selected entry.
REQ-015 Once iss_valid is asserted without iss_ready, a lock register SHALL hold the same entry selected, with stable outputs, until handshake or flush.
REQ-016 On iss_valid && iss_ready, the selected entry SHALL be invalidated at the edge and the lock released.
REQ-017 An entry freed by issue SHALL NOT be reused by a dispatch in the same cycle.
REQ-018 occupancy SHALL equal the count of valid entries in registered state.
REQ-019 With DEPTH-1 entries valid, simultaneous dispatch and issue SHALL leave occupancy unchanged.
REQ-020 flush SHALL invalidate all entries and release the lock at the edge, overriding same-cycle dispatch and issue.
REQ-021 Invalid entries SHALL NOT respond to cdb broadcasts.

Reset
REQ-022 On rst, all entries SHALL be invalid, the lock SHALL be cleared, occupancy SHALL be 0, iss_valid SHALL be 0 and disp_ready SHALL be 1 from the next cycle.
REQ-023 rst SHALL take precedence over flush, dispatch and issue, including mid-handshake.

Configuration
REQ-024 With macro RS_AGE_ORDER_EN defined, selection SHALL pick the oldest eligible entry by dispatch order, tracked by an age matrix updated on dispatch, issue and flush.
REQ-025 Without RS_AGE_ORDER_EN, selection SHALL pick the lowest-index eligible entry, and no age state SHALL be built.

Verification
REQ-026 Reset, then dispatch op=0x0011 dest=3 with both sources ready (5, 7) and iss_ready=1 -> iss_valid the next cycle with src1=5, src2=7, dest=3; occupancy 1→0.
REQ-027 Dispatch src1 waiting on tag 9; two cycles later drive cdb port1 tag 9 data 0xDEAD -> iss_valid in the following cycle with iss_src1=0xDEAD.
REQ-028 Dispatch with src2 tag 6 not ready while cdb port0 broadcasts tag 6 data 42 in the same cycle -> entry is eligible next cycle with src2=42.
REQ-029 Fill 4 entries with iss_ready=0 -> disp_ready=0, occupancy=4, iss outputs stable; wake a lower-index entry -> iss outputs still unchanged (lock); iss_ready=1 -> one entry retires, disp_ready=1.
REQ-030 With RS_AGE_ORDER_EN, dispatch into entries 2 then 0, both ready -> entry 2 issues first; without the macro -> entry 0 issues first.
REQ-031 Assert flush together with disp_valid and an issue handshake at 3 entries occupied -> occupancy=0, iss_valid=0 next cycle, and no dispatch recorded.

Source files
------------

// File: rtl/rs_generic.sv
// Generic reservation station: dispatch into free entries, CDB wakeup,
// single-issue select with a hold lock while the unit back-pressures.
// Optional macro RS_AGE_ORDER_EN: select the oldest eligible entry through
// an age matrix instead of the lowest-index eligible entry.
module rs_generic #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned OP_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_W-1:0]               disp_op,
    input  logic [TAG_W-1:0]              disp_dest,
    input  logic                          disp_src1_rdy,
    input  logic                          disp_src2_rdy,
    input  logic [TAG_W-1:0]              disp_src1_tag,
    input  logic [TAG_W-1:0]              disp_src2_tag,
    input  logic [XLEN-1:0]               disp_src1_val,
    input  logic [XLEN-1:0]               disp_src2_val,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [OP_W-1:0]               iss_op,
    output logic [TAG_W-1:0]              iss_dest,
    output logic [XLEN-1:0]               iss_src1,
    output logic [XLEN-1:0]               iss_src2,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    // Entry state
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0] s2_rdy_q, s2_rdy_d;
    logic [OP_W-1:0]  op_q     [DEPTH];
    logic [OP_W-1:0]  op_d     [DEPTH];
    logic [TAG_W-1:0] dest_q   [DEPTH];
    logic [TAG_W-1:0] dest_d   [DEPTH];
    logic [TAG_W-1:0] s1_tag_q [DEPTH];
    logic [TAG_W-1:0] s1_tag_d [DEPTH];
    logic [TAG_W-1:0] s2_tag_q [DEPTH];
    logic [TAG_W-1:0] s2_tag_d [DEPTH];
    logic [XLEN-1:0]  s1_val_q [DEPTH];
    logic [XLEN-1:0]  s1_val_d [DEPTH];
    logic [XLEN-1:0]  s2_val_q [DEPTH];
    logic [XLEN-1:0]  s2_val_d [DEPTH];

    // Issue lock
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

`ifdef RS_AGE_ORDER_EN
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
`endif

    logic [DEPTH-1:0] elig;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel_idx;

    // Lowest-index CDB match for a tag; lower ports overwrite higher ones
    function automatic logic cdb_lookup(
        input  logic [TAG_W-1:0]           tag,
        input  logic [CDB_PORTS-1:0]       vld,
        input  logic [CDB_PORTS*TAG_W-1:0] tags,
        input  logic [CDB_PORTS*XLEN-1:0]  datas,
        output logic [XLEN-1:0]            data
    );
        logic hit;
        hit  = 1'b0;
        data = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                hit  = 1'b1;
                data = datas[p*XLEN +: XLEN];
            end
        end
        return hit;
    endfunction

    assign elig = valid_q & s1_rdy_q & s2_rdy_q;

    // Lowest free entry and valid-entry count from registered state
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        occupancy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign disp_ready = free_found;

`ifdef RS_AGE_ORDER_EN
    // Oldest eligible entry: no other eligible entry is older than it
    always_comb begin
        logic blocked;
        pick_found = 1'b0;
        pick_idx   = '0;
        blocked    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && elig[j] && age_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            if (elig[i] && !blocked && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Lowest-index eligible entry
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // Locked entry stays selected; it cannot lose eligibility while held
    always_comb begin
        sel_idx   = lock_q ? lock_idx_q : pick_idx;
        iss_valid = lock_q | pick_found;
        iss_op    = op_q[sel_idx];
        iss_dest  = dest_q[sel_idx];
        iss_src1  = s1_val_q[sel_idx];
        iss_src2  = s2_val_q[sel_idx];
    end

    // Next state: wakeup, issue, dispatch, then flush overrides everything
    always_comb begin
        logic [XLEN-1:0] cap;
        logic            hit;
        valid_d    = valid_q;
        s1_rdy_d   = s1_rdy_q;
        s2_rdy_d   = s2_rdy_q;
        op_d       = op_q;
        dest_d     = dest_q;
        s1_tag_d   = s1_tag_q;
        s2_tag_d   = s2_tag_q;
        s1_val_d   = s1_val_q;
        s2_val_d   = s2_val_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        cap        = '0;
        hit        = 1'b0;
`ifdef RS_AGE_ORDER_EN
        age_d      = age_q;
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !s1_rdy_q[i]) begin
                hit = cdb_lookup(s1_tag_q[i], cdb_valid, cdb_tag, cdb_data, cap);
                if (hit) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = cap;
                end
            end
            if (valid_q[i] && !s2_rdy_q[i]) begin
                hit = cdb_lookup(s2_tag_q[i], cdb_valid, cdb_tag, cdb_data, cap);
                if (hit) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = cap;
                end
            end
        end

        if (iss_valid && iss_ready) begin
            valid_d[sel_idx] = 1'b0;
            lock_d           = 1'b0;
`ifdef RS_AGE_ORDER_EN
            age_d[sel_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][sel_idx] = 1'b0;
            end
`endif
        end else if (iss_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end

        // Target is invalid in registered state, so an issue-freed slot is never reused
        if (disp_valid && free_found) begin
            valid_d[free_idx]  = 1'b1;
            op_d[free_idx]     = disp_op;
            dest_d[free_idx]   = disp_dest;
            s1_tag_d[free_idx] = disp_src1_tag;
            s2_tag_d[free_idx] = disp_src2_tag;
            if (disp_src1_rdy) begin
                s1_rdy_d[free_idx] = 1'b1;
                s1_val_d[free_idx] = disp_src1_val;
            end else begin
                hit = cdb_lookup(disp_src1_tag, cdb_valid, cdb_tag, cdb_data, cap);
                s1_rdy_d[free_idx] = hit;
                s1_val_d[free_idx] = hit ? cap : disp_src1_val;
            end
            if (disp_src2_rdy) begin
                s2_rdy_d[free_idx] = 1'b1;
                s2_val_d[free_idx] = disp_src2_val;
            end else begin
                hit = cdb_lookup(disp_src2_tag, cdb_valid, cdb_tag, cdb_data, cap);
                s2_rdy_d[free_idx] = hit;
                s2_val_d[free_idx] = hit ? cap : disp_src2_val;
            end
`ifdef RS_AGE_ORDER_EN
            // New entry is younger than every currently valid entry
            age_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][free_idx] = valid_q[j] && (j != int'(free_idx));
            end
`endif
        end

        if (flush) begin
            valid_d = '0;
            lock_d  = 1'b0;
`ifdef RS_AGE_ORDER_EN
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j] = '0;
            end
`endif
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            s1_rdy_q   <= '0;
            s2_rdy_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            s1_rdy_q   <= s1_rdy_d;
            s2_rdy_q   <= s2_rdy_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Payload storage; only meaningful while the entry is valid
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        dest_q   <= dest_d;
        s1_tag_q <= s1_tag_d;
        s2_tag_q <= s2_tag_d;
        s1_val_q <= s1_val_d;
        s2_val_q <= s2_val_d;
    end

`ifdef RS_AGE_ORDER_EN
    // Age matrix
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_q[j] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end
`endif

endmodule

// File: tb/tb_rs_generic.sv
// Directed bench for rs_generic with default parameters.
module tb_rs_generic;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CDB_PORTS = 2;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned OP_W      = 16;
    localparam int unsigned OCC_W     = $clog2(DEPTH+1);

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [OP_W-1:0]            disp_op;
    logic [TAG_W-1:0]           disp_dest;
    logic                       disp_src1_rdy;
    logic                       disp_src2_rdy;
    logic [TAG_W-1:0]           disp_src1_tag;
    logic [TAG_W-1:0]           disp_src2_tag;
    logic [XLEN-1:0]            disp_src1_val;
    logic [XLEN-1:0]            disp_src2_val;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_data;
    logic                       iss_valid;
    logic                       iss_ready;
    logic [OP_W-1:0]            iss_op;
    logic [TAG_W-1:0]           iss_dest;
    logic [XLEN-1:0]            iss_src1;
    logic [XLEN-1:0]            iss_src2;
    logic [OCC_W-1:0]           occupancy;

    int total;
    int bad;

    rs_generic #(
        .DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_dest(disp_dest),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_dest(iss_dest),
        .iss_src1(iss_src1), .iss_src2(iss_src2),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] dest,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
        disp_valid    = 1'b1;
        disp_op       = 16'h0100 | 16'(dest);
        disp_dest     = dest;
        disp_src1_rdy = r1;
        disp_src1_tag = t1;
        disp_src1_val = v1;
        disp_src2_rdy = r2;
        disp_src2_tag = t2;
        disp_src2_val = v2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    endtask

    task automatic test_basic();
        iss_ready = 1'b1;
        set_disp(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        disp_op = 16'h0011;
        step();
        disp_valid = 1'b0;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_iss_valid got=%b exp=1", iss_valid); end
        total++; if (iss_src1 !== 32'd5) begin bad++; $display("FAIL basic_src1 got=%0h exp=5", iss_src1); end
        total++; if (iss_src2 !== 32'd7) begin bad++; $display("FAIL basic_src2 got=%0h exp=7", iss_src2); end
        total++; if (iss_dest !== 4'd3) begin bad++; $display("FAIL basic_dest got=%0d exp=3", iss_dest); end
        total++; if (iss_op !== 16'h0011) begin bad++; $display("FAIL basic_op got=%0h exp=11", iss_op); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ1 got=%0d exp=1", occupancy); end
        step();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL basic_occ0 got=%0d exp=0", occupancy); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", iss_valid); end
    endtask

    task automatic test_wakeup();
        iss_ready = 1'b1;
        set_disp(4'd4, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'h22);
        step();
        disp_valid = 1'b0;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_not_ready got=%b exp=0", iss_valid); end
        step();
        cdb_valid = 2'b10;
        cdb_tag   = {4'd9, 4'd0};
        cdb_data  = {32'hDEAD, 32'h0};
        step();
        cdb_valid = 2'b00;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL wake_iss_valid got=%b exp=1", iss_valid); end
        total++; if (iss_src1 !== 32'hDEAD) begin bad++; $display("FAIL wake_src1 got=%0h exp=dead", iss_src1); end
        total++; if (iss_src2 !== 32'h22) begin bad++; $display("FAIL wake_src2 got=%0h exp=22", iss_src2); end
        total++; if (iss_dest !== 4'd4) begin bad++; $display("FAIL wake_dest got=%0d exp=4", iss_dest); end
        step();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL wake_retire got=%0d exp=0", occupancy); end
    endtask

    task automatic test_disp_capture();
        iss_ready = 1'b0;
        set_disp(4'd5, 1'b1, 4'd0, 32'd11, 1'b0, 4'd6, 32'd0);
        cdb_valid = 2'b11;
        cdb_tag   = {4'd6, 4'd6};
        cdb_data  = {32'd99, 32'd42};
        step();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL cap_iss_valid got=%b exp=1", iss_valid); end
        total++; if (iss_src2 !== 32'd42) begin bad++; $display("FAIL cap_src2 got=%0d exp=42", iss_src2); end
        total++; if (iss_src1 !== 32'd11) begin bad++; $display("FAIL cap_src1 got=%0d exp=11", iss_src1); end
        iss_ready = 1'b1;
        step();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL cap_retire got=%0d exp=0", occupancy); end
    endtask

    task automatic test_fill_lock();
        logic [TAG_W-1:0] exp_dest;
        iss_ready = 1'b0;
        set_disp(4'd0, 1'b0, 4'd1, 32'd0,    1'b1, 4'd0, 32'hA0); step();
        set_disp(4'd1, 1'b1, 4'd0, 32'h10,   1'b1, 4'd0, 32'h11); step();
        set_disp(4'd2, 1'b1, 4'd0, 32'h20,   1'b1, 4'd0, 32'h21); step();
        set_disp(4'd3, 1'b0, 4'd2, 32'd0,    1'b1, 4'd0, 32'h31); step();
        disp_valid = 1'b0;
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_disp_ready got=%b exp=0", disp_ready); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
        total++; if (iss_dest !== 4'd1) begin bad++; $display("FAIL full_dest got=%0d exp=1", iss_dest); end
        total++; if (iss_src1 !== 32'h10) begin bad++; $display("FAIL full_src1 got=%0h exp=10", iss_src1); end
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd1};
        cdb_data  = {32'd0, 32'h55};
        step();
        cdb_valid = 2'b00;
        total++; if (iss_dest !== 4'd1) begin bad++; $display("FAIL lock_dest got=%0d exp=1", iss_dest); end
        total++; if (iss_src2 !== 32'h11) begin bad++; $display("FAIL lock_src2 got=%0h exp=11", iss_src2); end
        // Issue frees entry 1 while a blocked dispatch is pending; it must not land
        iss_ready = 1'b1;
        set_disp(4'd8, 1'b1, 4'd0, 32'h80, 1'b1, 4'd0, 32'h81);
        step();
        disp_valid = 1'b0;
        iss_ready  = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL retire_occ got=%0d exp=3", occupancy); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL retire_disp_ready got=%b exp=1", disp_ready); end
        total++; if (iss_dest !== 4'd0) begin bad++; $display("FAIL unlock_dest got=%0d exp=0", iss_dest); end
        total++; if (iss_src1 !== 32'h55) begin bad++; $display("FAIL unlock_src1 got=%0h exp=55", iss_src1); end
        // DEPTH-1 valid: dispatch and issue together keep the count
        iss_ready = 1'b1;
        set_disp(4'd9, 1'b1, 4'd0, 32'h90, 1'b1, 4'd0, 32'h91);
        step();
        disp_valid = 1'b0;
        iss_ready  = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL swap_occ got=%0d exp=3", occupancy); end
`ifdef RS_AGE_ORDER_EN
        exp_dest = 4'd2;
`else
        exp_dest = 4'd9;
`endif
        total++; if (iss_dest !== exp_dest) begin bad++; $display("FAIL swap_dest got=%0d exp=%0d", iss_dest, exp_dest); end
    endtask

    task automatic test_flush();
        flush     = 1'b1;
        iss_ready = 1'b1;
        set_disp(4'd12, 1'b1, 4'd0, 32'hC0, 1'b1, 4'd0, 32'hC1);
        step();
        flush      = 1'b0;
        disp_valid = 1'b0;
        iss_ready  = 1'b0;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_iss_valid got=%b exp=0", iss_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL flush_disp_ready got=%b exp=1", disp_ready); end
        step();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ_hold got=%0d exp=0", occupancy); end
    endtask

    task automatic test_age_order();
        logic [TAG_W-1:0] exp_dest;
        iss_ready = 1'b0;
        set_disp(4'd0, 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'd1); step();
        set_disp(4'd1, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd1); step();
        set_disp(4'd2, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd1); step();
        disp_valid = 1'b0;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL age_idle got=%b exp=0", iss_valid); end
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd1};
        cdb_data  = {32'd0, 32'h15};
        iss_ready = 1'b1;
        step();
        cdb_valid = 2'b00;
        total++; if (iss_dest !== 4'd0) begin bad++; $display("FAIL age_first_dest got=%0d exp=0", iss_dest); end
        step();
        // Entry 0 is free again; refill it after entry 2 and wake entry 2 together
        iss_ready = 1'b0;
        set_disp(4'd10, 1'b1, 4'd0, 32'hA0, 1'b1, 4'd0, 32'hA1);
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd3};
        cdb_data  = {32'd0, 32'h33};
        step();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
`ifdef RS_AGE_ORDER_EN
        exp_dest = 4'd2;
`else
        exp_dest = 4'd10;
`endif
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL age_iss_valid got=%b exp=1", iss_valid); end
        total++; if (iss_dest !== exp_dest) begin bad++; $display("FAIL age_pick got=%0d exp=%0d", iss_dest, exp_dest); end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        iss_ready = 1'b0;
        set_disp(4'd6, 1'b1, 4'd0, 32'h60, 1'b1, 4'd0, 32'h61);
        step();
        disp_valid = 1'b0;
        step();
        rst       = 1'b1;
        iss_ready = 1'b1;
        set_disp(4'd7, 1'b1, 4'd0, 32'h70, 1'b1, 4'd0, 32'h71);
        step();
        rst        = 1'b0;
        disp_valid = 1'b0;
        iss_ready  = 1'b0;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rstmid_iss_valid got=%b exp=0", iss_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL rstmid_disp_ready got=%b exp=1", disp_ready); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_op       = '0;
        disp_dest     = '0;
        disp_src1_rdy = 1'b0;
        disp_src2_rdy = 1'b0;
        disp_src1_tag = '0;
        disp_src2_tag = '0;
        disp_src1_val = '0;
        disp_src2_val = '0;
        cdb_valid     = '0;
        cdb_tag       = '0;
        cdb_data      = '0;
        iss_ready     = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_disp_capture();
        test_fill_lock();
        test_flush();
        test_age_order();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
